// File: rtl/histeq_pkg.sv
// histeq_pkg: shared constants and the controller state enumeration for the
// histogram-equalisation controller.
package histeq_pkg;

    localparam int LEVELS    = 256;  // grey levels, one histogram bin each
    localparam int LVL_W     = 8;    // width of a grey level / bin address
    localparam int CNT_W_DEF = 20;   // default width of a bin count

    localparam int DRAIN_CYC = 2;    // cycles spent emptying the RMW pipeline
    localparam int SWEEP_LAT = 2;    // SWEEP entry to first LUT strobe

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_SWEEP,
        ST_CLEAR_POST
    } state_t;

endpackage

// File: rtl/hist_ram.sv
// hist_ram: 256 x CNT_W simple dual-port histogram bin memory.
// One synchronous write port, one read port with a registered (1-cycle) read.
// A same-cycle read of the address being written returns the old contents.
module hist_ram
    import histeq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LVL_W-1:0] waddr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [LVL_W-1:0] raddr,
    output logic [CNT_W-1:0] rdata
);

    logic [CNT_W-1:0] mem [LEVELS];

    // Bin write and registered read.
    // NOTE: neither the array nor the read register has a reset, so the block
    // maps onto block RAM; the controller zeroes every bin in CLEAR instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/histeq_ctrl.sv
// histeq_ctrl: builds a grey-level histogram of one frame, then sweeps the
// cumulative distribution out to the equalisation LUT, then clears the bins.
// Optional build macro HISTEQ_PIXCHK_EN adds a pixel counter and the sticky
// frame_err output flagging frames whose pixel count differs from IMG_TOTAL.
module histeq_ctrl
    import histeq_pkg::*;
#(
    parameter int IMG_TOTAL = 480000,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_img_vsync,
    input  logic             per_img_href,
    input  logic [7:0]       per_img_gray,
    output logic [7:0]       pixel_level,
    output logic [CNT_W-1:0] pixel_level_acc_num,
    output logic             pixel_level_valid,
    output logic             busy,
    output logic             frame_done
`ifdef HISTEQ_PIXCHK_EN
    ,
    output logic             frame_err
`endif
);

    // ------------------------------------------------------------------
    // State, phase counter and vsync edge detection
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;   // phase counter; 9 bits for the sweep tail
    logic       armed_q;        // low only in the cycle right after reset
    logic       vs_q;

    logic vs_rise, vs_fall, accept, clearing, sweep_rd;

    assign vs_rise  = per_img_vsync & ~vs_q;
    assign vs_fall  = ~per_img_vsync & vs_q;
    // href is ignored from the vsync falling cycle on.
    assign accept   = (state_q == ST_ACCUM) & per_img_href & per_img_vsync;
    assign clearing = ((state_q == ST_CLEAR) & armed_q) | (state_q == ST_CLEAR_POST);
    assign sweep_rd = (state_q == ST_SWEEP) & ~cnt_q[8];

    // RMW pipeline write stage and forwarding registers.
    logic             wr_v_q;
    logic [LVL_W-1:0] wr_addr_q;
    logic             fwd_hit_q;
    logic [CNT_W-1:0] fwd_data_q;
    logic [CNT_W-1:0] operand, inc_val;

    // Sweep pipeline and running sum.
    logic             sw_v_q;
    logic [LVL_W-1:0] sw_lvl_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W:0]   sum_full;
    logic [CNT_W-1:0] sum_sat;

    // Bin memory ports.
    logic             ram_we;
    logic [LVL_W-1:0] ram_waddr, ram_raddr;
    logic [CNT_W-1:0] ram_wdata, ram_rdata;

    // State register, phase counter and vsync history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this clock edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
            vs_q    <= per_img_vsync;
        end
    end

    // Next-state and phase-counter logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR, ST_CLEAR_POST: begin
                if (armed_q) begin
                    if (cnt_q[7:0] == 8'(LEVELS - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (vs_rise) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end
            end
            ST_ACCUM: begin
                if (vs_fall) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 9'(DRAIN_CYC - 1)) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_SWEEP: begin
                // Reads run for cnt 0..255; the tail waits out the read and
                // sum latency until level 255 is on the outputs.
                if (cnt_q == 9'(LEVELS + SWEEP_LAT - 1)) begin
                    state_d = ST_CLEAR_POST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-modify-write pipeline: issue (read) stage then write stage.
    // A pixel hitting the bin currently in the write stage would read stale
    // data from the RAM, so the written value is forwarded instead.
    // ------------------------------------------------------------------
    assign operand = fwd_hit_q ? fwd_data_q : ram_rdata;
    assign inc_val = (operand == '1) ? operand : operand + CNT_W'(1);

    // Write-stage and forwarding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_v_q     <= 1'b0;
            wr_addr_q  <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            wr_v_q     <= accept;
            wr_addr_q  <= per_img_gray;
            fwd_hit_q  <= accept & wr_v_q & (per_img_gray == wr_addr_q);
            fwd_data_q <= inc_val;
        end
    end

    // Bin memory port steering: clear, histogram update or sweep read.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = per_img_gray;
        if (clearing) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q[7:0];
        end else if (wr_v_q) begin
            ram_we    = 1'b1;
            ram_waddr = wr_addr_q;
            ram_wdata = inc_val;
        end
        if (state_q == ST_SWEEP) begin
            ram_raddr = cnt_q[7:0];
        end
    end

    hist_ram #(
        .CNT_W (CNT_W)
    ) u_hist_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Sweep: running saturating sum and LUT output registers
    // ------------------------------------------------------------------
    assign sum_full = {1'b0, acc_q} + {1'b0, ram_rdata};
    assign sum_sat  = sum_full[CNT_W] ? '1 : sum_full[CNT_W-1:0];

    // Sweep read tracking, running sum and registered LUT outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_v_q              <= 1'b0;
            sw_lvl_q            <= '0;
            acc_q               <= '0;
            pixel_level_valid   <= 1'b0;
            pixel_level         <= '0;
            pixel_level_acc_num <= '0;
        end else begin
            sw_v_q   <= sweep_rd;
            sw_lvl_q <= cnt_q[7:0];
            if (state_q != ST_SWEEP) begin
                acc_q <= '0;
            end else if (sw_v_q) begin
                acc_q <= sum_sat;
            end
            pixel_level_valid   <= sw_v_q;
            pixel_level         <= sw_v_q ? sw_lvl_q : '0;
            pixel_level_acc_num <= sw_v_q ? sum_sat : '0;
        end
    end

    assign busy       = armed_q & (state_q != ST_IDLE);
    assign frame_done = clearing & (cnt_q[7:0] == 8'(LEVELS - 1));

`ifdef HISTEQ_PIXCHK_EN
    // ------------------------------------------------------------------
    // Pixel-count check
    // ------------------------------------------------------------------
    logic [CNT_W:0] pix_cnt_q;
    logic           frame_err_q;

    // Count accepted pixels per frame; flag a mismatch when DRAIN is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && vs_rise) begin
                pix_cnt_q <= '0;
            end else if (accept && (pix_cnt_q != '1)) begin
                pix_cnt_q <= pix_cnt_q + (CNT_W+1)'(1);
            end
            if ((state_q == ST_ACCUM) && vs_fall &&
                (pix_cnt_q != (CNT_W+1)'(IMG_TOTAL))) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    assign frame_err = frame_err_q;
`else
    // IMG_TOTAL only feeds the pixel-count check, absent in this build.
    localparam int unused_img_total = IMG_TOTAL;
`endif

endmodule

// File: tb/tb_histeq_ctrl.sv
// tb_histeq_ctrl: directed self-checking bench for histeq_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
// With HISTEQ_PIXCHK_EN defined the pixel-count check is exercised too.
`timescale 1ns/1ps
module tb_histeq_ctrl;

    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             per_img_vsync = 1'b0;
    logic             per_img_href = 1'b0;
    logic [7:0]       per_img_gray = '0;
    logic [7:0]       pixel_level;
    logic [CNT_W-1:0] pixel_level_acc_num;
    logic             pixel_level_valid;
    logic             busy;
    logic             frame_done;
`ifdef HISTEQ_PIXCHK_EN
    logic             frame_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]       pix_q [$];
    logic [CNT_W-1:0] got_acc [256];
    int               sweep_bad;
    int               sweep_lat;
    int               done_pulses;

    always #5 clk = ~clk;

    histeq_ctrl #(
        .IMG_TOTAL (64),
        .CNT_W     (CNT_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .per_img_vsync       (per_img_vsync),
        .per_img_href        (per_img_href),
        .per_img_gray        (per_img_gray),
        .pixel_level         (pixel_level),
        .pixel_level_acc_num (pixel_level_acc_num),
        .pixel_level_valid   (pixel_level_valid),
        .busy                (busy),
        .frame_done          (frame_done)
`ifdef HISTEQ_PIXCHK_EN
        ,
        .frame_err           (frame_err)
`endif
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame from pix_q; returns on the cycle vsync is lowered.
    task automatic send_frame();
        per_img_vsync = 1'b1;
        cyc(2);
        foreach (pix_q[i]) begin
            per_img_href = 1'b1;
            per_img_gray = pix_q[i];
            cyc(1);
        end
        per_img_href = 1'b0;
        per_img_gray = '0;
        cyc(1);
        per_img_vsync = 1'b0;
    endtask

    // Capture one sweep into got_acc; sweep_bad counts framing errors.
    task automatic collect_sweep();
        int w;
        w = 0;
        sweep_bad = 0;
        for (int k = 0; k < 256; k++) got_acc[k] = '0;
        while (pixel_level_valid !== 1'b1 && w < 1000) begin
            cyc(1);
            w++;
        end
        sweep_lat = w;
        if (w >= 1000) begin
            sweep_bad = 256;
        end else begin
            for (int k = 0; k < 256; k++) begin
                if (pixel_level_valid !== 1'b1 || pixel_level !== 8'(k)) sweep_bad++;
                got_acc[k] = pixel_level_acc_num;
                cyc(1);
            end
            if (pixel_level_valid !== 1'b0 || pixel_level !== 8'd0 ||
                pixel_level_acc_num !== '0) sweep_bad++;
        end
    endtask

    // Wait for busy to drop, counting frame_done pulses on the way.
    task automatic wait_idle();
        int w;
        w = 0;
        done_pulses = 0;
        while (busy !== 1'b0 && w < 1000) begin
            if (frame_done === 1'b1) done_pulses++;
            cyc(1);
            w++;
        end
    endtask

    task automatic test_reset();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        cyc(1);
        rst_n = 1'b0;
        cyc(3);
        n_tests++;
        if (pixel_level_valid !== 1'b0 || pixel_level !== 8'd0 || pixel_level_acc_num !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b level=%0d acc=%0d, want all 0",
                     pixel_level_valid, pixel_level, pixel_level_acc_num);
        end
        n_tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: busy=%b frame_done=%b, want 0 0", busy, frame_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            // A vsync pulse during CLEAR must be ignored.
            if (i == 100) per_img_vsync = 1'b1;
            if (i == 120) per_img_vsync = 1'b0;
            cyc(1);
            if (busy === 1'b1) busy_cnt++;
            if (frame_done === 1'b1) done_cnt++;
        end
        n_tests++;
        if (busy_cnt != 256) begin
            n_fail++;
            $display("FAIL clear_busy_cycles: got %0d, want 256", busy_cnt);
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL clear_frame_done: got %0d pulses, want 1", done_cnt);
        end
    endtask

    task automatic test_ramp16();
        logic [CNT_W-1:0] exp_v;
        pix_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back(8'(i));
        send_frame();
        collect_sweep();
        wait_idle();
        n_tests++;
        if (sweep_lat != 5) begin
            n_fail++;
            $display("FAIL ramp16_latency: first strobe %0d cycles after vsync fall, want 5", sweep_lat);
        end
        n_tests++;
        if (sweep_bad != 0) begin
            n_fail++;
            $display("FAIL ramp16_strobes: %0d framing errors, want 0", sweep_bad);
        end
        for (int k = 0; k < 256; k++) begin
            exp_v = (k <= 15) ? CNT_W'(k + 1) : CNT_W'(16);
            n_tests++;
            if (got_acc[k] !== exp_v) begin
                n_fail++;
                $display("FAIL ramp16_acc[%0d]: got %0d, want %0d", k, got_acc[k], exp_v);
            end
        end
        n_tests++;
        if (done_pulses != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp16_done: pulses=%0d busy=%b, want 1 0", done_pulses, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] exp_v;
        // Adjacent and one-apart repeats: bins 5 and 6 end at 3 each.
        pix_q = '{8'd5, 8'd5, 8'd6, 8'd5, 8'd6, 8'd6};
        send_frame();
        collect_sweep();
        wait_idle();
        n_tests++;
        if (sweep_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_strobes: %0d framing errors, want 0", sweep_bad);
        end
        for (int k = 0; k < 256; k++) begin
            exp_v = (k < 5) ? CNT_W'(0) : (k == 5) ? CNT_W'(3) : CNT_W'(6);
            n_tests++;
            if (got_acc[k] !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_acc[%0d]: got %0d, want %0d", k, got_acc[k], exp_v);
            end
        end
    endtask

    task automatic test_run7();
        logic [CNT_W-1:0] exp_v;
        pix_q.delete();
        for (int i = 0; i < 1000; i++) pix_q.push_back(8'd7);
        send_frame();
        collect_sweep();
        wait_idle();
        n_tests++;
        if (sweep_bad != 0) begin
            n_fail++;
            $display("FAIL run7_strobes: %0d framing errors, want 0", sweep_bad);
        end
        for (int k = 0; k < 256; k++) begin
            exp_v = (k < 7) ? CNT_W'(0) : CNT_W'(1000);
            n_tests++;
            if (got_acc[k] !== exp_v) begin
                n_fail++;
                $display("FAIL run7_acc[%0d]: got %0d, want %0d", k, got_acc[k], exp_v);
            end
        end
    endtask

    task automatic test_empty_frame();
        int nonzero;
        nonzero = 0;
        pix_q.delete();
        send_frame();
        collect_sweep();
        wait_idle();
        n_tests++;
        if (sweep_bad != 0) begin
            n_fail++;
            $display("FAIL empty_strobes: %0d framing errors, want 0", sweep_bad);
        end
        for (int k = 0; k < 256; k++) if (got_acc[k] !== '0) nonzero++;
        n_tests++;
        if (nonzero != 0) begin
            n_fail++;
            $display("FAIL empty_acc: %0d nonzero levels, want 0", nonzero);
        end
    endtask

    task automatic test_drop();
        logic [CNT_W-1:0] exp_v;
        // Frame A: four pixels at grey 50.
        pix_q = '{8'd50, 8'd50, 8'd50, 8'd50};
        send_frame();
        fork
            collect_sweep();
            begin
                // Frame B starts 10 cycles into A's sweep and must be dropped.
                cyc(13);
                per_img_vsync = 1'b1;
                cyc(2);
                repeat (20) begin
                    per_img_href = 1'b1;
                    per_img_gray = 8'd0;
                    cyc(1);
                end
                per_img_href = 1'b0;
                cyc(1);
                per_img_vsync = 1'b0;
            end
        join
        wait_idle();
        n_tests++;
        if (sweep_bad != 0 || got_acc[49] !== '0 || got_acc[50] !== CNT_W'(4) ||
            got_acc[255] !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL drop_frame_a: bad=%0d acc49=%0d acc50=%0d acc255=%0d, want 0 0 4 4",
                     sweep_bad, got_acc[49], got_acc[50], got_acc[255]);
        end
        // Frame C must sweep exactly as it would on its own.
        cyc(3);
        pix_q = '{8'd128, 8'd255, 8'd128};
        send_frame();
        collect_sweep();
        wait_idle();
        n_tests++;
        if (sweep_bad != 0) begin
            n_fail++;
            $display("FAIL drop_frame_c_strobes: %0d framing errors, want 0", sweep_bad);
        end
        for (int k = 0; k < 256; k++) begin
            exp_v = (k < 128) ? CNT_W'(0) : (k < 255) ? CNT_W'(2) : CNT_W'(3);
            n_tests++;
            if (got_acc[k] !== exp_v) begin
                n_fail++;
                $display("FAIL drop_frame_c_acc[%0d]: got %0d, want %0d", k, got_acc[k], exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int w;
        logic [CNT_W-1:0] exp_v;
        w = 0;
        pix_q = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
        send_frame();
        while (!(pixel_level_valid === 1'b1 && pixel_level === 8'd100) && w < 1000) begin
            cyc(1);
            w++;
        end
        n_tests++;
        if (pixel_level !== 8'd100 || pixel_level_acc_num !== CNT_W'(5)) begin
            n_fail++;
            $display("FAIL midsweep_level100: level=%0d acc=%0d, want 100 5",
                     pixel_level, pixel_level_acc_num);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (pixel_level_valid !== 1'b0 || pixel_level !== 8'd0 || pixel_level_acc_num !== '0 ||
            busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_async_reset: valid=%b level=%0d acc=%0d busy=%b done=%b, want all 0",
                     pixel_level_valid, pixel_level, pixel_level_acc_num, busy, frame_done);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        wait_idle();
        n_tests++;
        if (done_pulses != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_clear: pulses=%0d busy=%b, want 1 0", done_pulses, busy);
        end
        // Next frame: bin 3 twice, bin 9 once.
        pix_q = '{8'd3, 8'd9, 8'd3};
        send_frame();
        collect_sweep();
        wait_idle();
        n_tests++;
        if (sweep_bad != 0) begin
            n_fail++;
            $display("FAIL midsweep_next_strobes: %0d framing errors, want 0", sweep_bad);
        end
        for (int k = 0; k < 256; k++) begin
            exp_v = (k < 3) ? CNT_W'(0) : (k < 9) ? CNT_W'(2) : CNT_W'(3);
            n_tests++;
            if (got_acc[k] !== exp_v) begin
                n_fail++;
                $display("FAIL midsweep_next_acc[%0d]: got %0d, want %0d", k, got_acc[k], exp_v);
            end
        end
    endtask

`ifdef HISTEQ_PIXCHK_EN
    task automatic test_pixchk();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        wait_idle();
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pixchk_after_reset: frame_err=%b, want 0", frame_err);
        end
        pix_q.delete();
        for (int i = 0; i < 63; i++) pix_q.push_back(8'(i));
        send_frame();
        cyc(1);
        n_tests++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL pixchk_63_err: frame_err=%b at DRAIN entry, want 1", frame_err);
        end
        collect_sweep();
        wait_idle();
        n_tests++;
        if (sweep_bad != 0 || got_acc[255] !== CNT_W'(63) || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL pixchk_63_sweep: bad=%0d acc255=%0d err=%b, want 0 63 1",
                     sweep_bad, got_acc[255], frame_err);
        end
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        wait_idle();
        pix_q.delete();
        for (int i = 0; i < 64; i++) pix_q.push_back(8'(i));
        send_frame();
        cyc(1);
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pixchk_64_err: frame_err=%b at DRAIN entry, want 0", frame_err);
        end
        collect_sweep();
        wait_idle();
        n_tests++;
        if (sweep_bad != 0 || got_acc[255] !== CNT_W'(64)) begin
            n_fail++;
            $display("FAIL pixchk_64_sweep: bad=%0d acc255=%0d, want 0 64", sweep_bad, got_acc[255]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp16();
        test_back_to_back();
        test_run7();
        test_empty_frame();
        test_drop();
        test_reset_mid_sweep();
`ifdef HISTEQ_PIXCHK_EN
        test_pixchk();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/histeq_ctrl.md
HISTEQ_CTRL -- requirements
Module: histeq_ctrl

Interface
REQ-001 Parameter IMG_TOTAL, default 480000: expected pixels per frame; used only by the pixel-count check.
REQ-002 Parameter CNT_W, default 20: width of each bin count and of the cumulative count.
REQ-003 clk  input  1  clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 per_img_vsync  input  1  frame envelope; high while the frame is active.
REQ-006 per_img_href  input  1  pixel valid qualifier.
REQ-007 per_img_gray  input  8  pixel grey level.
REQ-008 pixel_level  output  8  CDF bin index being delivered to the equalisation LUT.
REQ-009 pixel_level_acc_num  output  CNT_W  cumulative count of bins 0..pixel_level.
REQ-010 pixel_level_valid  output  1  LUT write strobe.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 frame_done  output  1  one-cycle pulse when the sweep and clear for a frame are complete.
REQ-013 frame_err  output  1  sticky pixel-count mismatch flag; present only with HISTEQ_PIXCHK_EN.

Function
REQ-014 States:
- CLEAR: 256 cycles, zero-writes bins 0..255.
- IDLE
- ACCUM
- DRAIN: 2 cycles.
- SWEEP: 256 cycles.
- CLEAR_POST: 256 cycles.
REQ-015 IDLE -> ACCUM on a vsync rising edge (vsync high this cycle, low the previous cycle); any other vsync activity in IDLE is ignored.
REQ-016 ACCUM increments bin[per_img_gray] once per cycle with href high, through a 2-stage read-modify-write pipeline, sustaining one pixel per cycle.
REQ-017 RMW hazard: when the incoming pixel hits the bin currently in the write stage, the write-stage value is forwarded; N consecutive identical pixels add exactly N.
REQ-018 Bin increment saturates at 2^CNT_W-1.
REQ-019 ACCUM -> DRAIN on a vsync falling edge; href is ignored from that cycle on.
REQ-020 DRAIN -> SWEEP after 2 cycles, once the RMW pipeline is empty.
REQ-021 SWEEP reads bins 0..255 in order and keeps a running saturating sum.
REQ-022 SWEEP delivery: pixel_level_valid is high for exactly 256 consecutive cycles, with pixel_level = k and pixel_level_acc_num = sum(bin[0..k]).
REQ-023 SWEEP latency: the first valid output occurs 2 cycles after SWEEP entry.
REQ-024 When pixel_level_valid is low, pixel_level and pixel_level_acc_num hold 0.
REQ-025 SWEEP -> CLEAR_POST after level 255 is delivered.
REQ-026 CLEAR_POST -> IDLE, with frame_done pulsed in the last CLEAR_POST cycle.
REQ-027 A vsync rising edge during DRAIN, SWEEP or CLEAR_POST does not start accumulation; that frame is dropped whole.
REQ-028 After a dropped frame, accumulation resumes only on the next rising edge seen in IDLE.
REQ-029 A frame with zero href pixels still sweeps; all 256 outputs carry acc_num = 0.

Reset
REQ-030 On rst_n low, all outputs are 0 asynchronously, the pipeline is flushed and the state is CLEAR; this applies mid-ACCUM and mid-SWEEP alike.
REQ-031 Bin memory content is undefined after reset, so CLEAR runs first; busy is high during it, and vsync edges during CLEAR are ignored.

Configuration
REQ-032 HISTEQ_PIXCHK_EN defined: a CNT_W+1-bit counter counts accepted pixels in ACCUM.
REQ-033 With HISTEQ_PIXCHK_EN, at DRAIN entry a count != IMG_TOTAL sets frame_err; frame_err clears only on reset, and the sweep still runs.
REQ-034 HISTEQ_PIXCHK_EN undefined: no counter exists, and frame_err is absent from the port list.

Structure
REQ-035 Package histeq_pkg holds:
- LEVELS = 256
- the CNT_W default
- the state enumeration
- the DRAIN and SWEEP latency constants
REQ-036 Sub-module hist_ram holds the bin memory: 256 x CNT_W simple dual-port, synchronous write, 1-cycle registered read, inferable as block RAM.
REQ-037 histeq_ctrl owns the FSM, the RMW pipeline with forwarding, the running sum and the output registers.

Verification
REQ-038 Reset then idle for 300 cycles -> busy high for exactly 256 cycles and frame_done pulses once.
REQ-039 Frame of 16 pixels, gray 0..15 each once -> acc_num = k+1 for k<=15 and 16 for k>=15; 256 contiguous strobes.
REQ-040 Frame of 1000 consecutive gray=7 pixels -> acc_num is 0 for k<7 and 1000 for k>=7; proves forwarding.
REQ-041 Second vsync rising edge 10 cycles into SWEEP -> the second frame is dropped; the third frame's sweep equals a standalone run of it.
REQ-042 rst_n low at SWEEP level 100 -> outputs 0 at once; after release, CLEAR runs and the next frame is unaffected.
REQ-043 With HISTEQ_PIXCHK_EN and IMG_TOTAL=64, a 63-pixel frame -> frame_err = 1 at DRAIN entry; a 64-pixel frame after reset -> frame_err = 0.
